// File: rtl/cpu_wrapper_v3.sv
// cpu_wrapper_v3: 8-bit accumulator-style CPU with a 5-stage pipeline
// (IF, ID, EX, MEM, WB), full forwarding, unified 256x8 program memory,
// 4x8 register file and a 3-bit condition-code register {N, Z, C}.

// Program memory: asynchronous read, zero-filled at time zero, untouched by reset.
module cpu_mem (
  input  logic [7:0] i_addr,
  output logic [7:0] o_data
);
  logic [7:0] mem [0:255] = '{default: 8'h00};

  assign o_data = mem[i_addr];
endmodule

// Program counter: cleared by reset, advances by one per enabled cycle (wraps).
module cpu_pc (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_en,
  output logic [7:0] o_pc
);
  logic [7:0] pc_current;

  // Counter register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rstn)      pc_current <= '0;
    else if (i_en) pc_current <= pc_current + 8'd1;
  end

  assign o_pc = pc_current;
endmodule

// 4x8 register file, one write port (WB) and two write-through read ports (ID).
module cpu_regfile (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_we,
  input  logic [1:0] i_wa,
  input  logic [7:0] i_wd,
  input  logic [1:0] i_ra_a,
  input  logic [1:0] i_ra_b,
  output logic [7:0] o_rd_a,
  output logic [7:0] o_rd_b
);
  logic [7:0] regs [0:3];

  // Register storage: cleared on reset, written from WB
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (i_we) begin
      regs[i_wa] <= i_wd;
    end
  end

  // Read ports return the value being written in the same cycle
  always_comb begin
    o_rd_a = regs[i_ra_a];
    o_rd_b = regs[i_ra_b];
    if (i_we && (i_wa == i_ra_a)) o_rd_a = i_wd;
    if (i_we && (i_wa == i_ra_b)) o_rd_b = i_wd;
  end
endmodule

// Condition-code register, bit order {N, Z, C}.
module cpu_ccr (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_we,
  input  logic [2:0] i_d,
  output logic [2:0] o_q
);
  logic [2:0] CCR_reg;

  // Flag register, updated at the end of EX
  always_ff @(posedge clk) begin
    if (rstn)      CCR_reg <= '0;
    else if (i_we) CCR_reg <= i_d;
  end

  assign o_q = CCR_reg;
endmodule

module cpu_wrapper_v3 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] I_Port,
  input  logic       int_sig,
  output logic [7:0] O_Port
);
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t     r_state, w_state_next;
  logic       w_fetch_en, w_halt_dec;
  logic [7:0] w_pc, w_fetch_data;

  logic       r_ifid_valid;
  logic [7:0] r_ifid_instr;
  logic       r_idex_valid;
  logic [7:0] r_idex_instr, r_idex_a, r_idex_b;
  logic [7:0] w_rd_a, w_rd_b;

  logic       r_exmem_valid, r_exmem_we, r_exmem_out;
  logic [1:0] r_exmem_rd;
  logic [7:0] r_exmem_res;
  logic       r_memwb_valid, r_memwb_we;
  logic [1:0] r_memwb_rd;
  logic [7:0] r_memwb_res;

  logic [3:0] w_op;
  logic [1:0] w_ra, w_rb, w_rd;
  logic [7:0] w_opa, w_opb, w_res;
  logic [8:0] w_sum;
  logic       w_we, w_out;
  logic       w_c_upd, w_zn_upd, w_c_new, w_ccr_we;
  logic [2:0] w_ccr, w_ccr_next;
  logic       w_rf_we;
  logic [7:0] r_oport;
  logic       w_unused_int;

  // Interrupt request is reserved and has no effect
  assign w_unused_int = int_sig;

  cpu_mem mem_inst (
    .i_addr (w_pc),
    .o_data (w_fetch_data)
  );

  cpu_pc PC (
    .clk  (clk),
    .rstn (rstn),
    .i_en (w_fetch_en),
    .o_pc (w_pc)
  );

  assign w_rf_we = r_memwb_valid & r_memwb_we;

  cpu_regfile regfile_inst (
    .clk    (clk),
    .rstn   (rstn),
    .i_we   (w_rf_we),
    .i_wa   (r_memwb_rd),
    .i_wd   (r_memwb_res),
    .i_ra_a (r_ifid_instr[3:2]),
    .i_ra_b (r_ifid_instr[1:0]),
    .o_rd_a (w_rd_a),
    .o_rd_b (w_rd_b)
  );

  cpu_ccr ccr_inst (
    .clk  (clk),
    .rstn (rstn),
    .i_we (w_ccr_we),
    .i_d  (w_ccr_next),
    .o_q  (w_ccr)
  );

  // Only a valid decoded HALT stops fetch; reset-filled bubbles never do
  assign w_halt_dec = r_ifid_valid && (r_ifid_instr[7:4] == 4'd0);

  // Run/halt state register
  always_ff @(posedge clk) begin
    if (rstn) r_state <= S_RUN;
    else      r_state <= w_state_next;
  end

  // Fetch enable and halt entry; the decode cycle of HALT already blocks fetch
  always_comb begin
    w_state_next = r_state;
    w_fetch_en   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_halt_dec) w_state_next = S_HALT;
        else            w_fetch_en   = 1'b1;
      end
      S_HALT:  w_fetch_en   = 1'b0;
      default: w_state_next = S_RUN;
    endcase
  end

  assign w_op = r_idex_instr[7:4];
  assign w_ra = r_idex_instr[3:2];
  assign w_rb = r_idex_instr[1:0];

  // EX operand forwarding, younger (EX/MEM) result takes priority over MEM/WB
  always_comb begin
    w_opa = r_idex_a;
    w_opb = r_idex_b;
    if (r_exmem_valid && r_exmem_we && (r_exmem_rd == w_ra))      w_opa = r_exmem_res;
    else if (r_memwb_valid && r_memwb_we && (r_memwb_rd == w_ra)) w_opa = r_memwb_res;
    if (r_exmem_valid && r_exmem_we && (r_exmem_rd == w_rb))      w_opb = r_exmem_res;
    else if (r_memwb_valid && r_memwb_we && (r_memwb_rd == w_rb)) w_opb = r_memwb_res;
  end

  // Execute: ALU result, destination, OUT strobe and flag updates
  always_comb begin
    w_res    = '0;
    w_we     = 1'b0;
    w_rd     = w_ra;
    w_out    = 1'b0;
    w_sum    = '0;
    w_c_new  = w_ccr[0];
    w_c_upd  = 1'b0;
    w_zn_upd = 1'b0;
    if (r_idex_valid) begin
      case (w_op)
        4'd1: begin
          w_res = w_opb;
          w_we  = 1'b1;
        end
        4'd2: begin
          w_sum    = {1'b0, w_opa} + {1'b0, w_opb};
          w_res    = w_sum[7:0];
          w_c_new  = w_sum[8];
          w_we     = 1'b1;
          w_c_upd  = 1'b1;
          w_zn_upd = 1'b1;
        end
        4'd3: begin
          w_res    = w_opa - w_opb;
          w_c_new  = (w_opa < w_opb);
          w_we     = 1'b1;
          w_c_upd  = 1'b1;
          w_zn_upd = 1'b1;
        end
        4'd4: begin
          w_res    = w_opa & w_opb;
          w_we     = 1'b1;
          w_zn_upd = 1'b1;
        end
        4'd5: begin
          w_res    = w_opa | w_opb;
          w_we     = 1'b1;
          w_zn_upd = 1'b1;
        end
        4'd6: begin
          case (w_ra)
            2'd0: begin
              w_res    = {w_opb[6:0], w_ccr[0]};
              w_c_new  = w_opb[7];
              w_rd     = w_rb;
              w_we     = 1'b1;
              w_c_upd  = 1'b1;
              w_zn_upd = 1'b1;
            end
            2'd1: begin
              w_res    = {w_ccr[0], w_opb[7:1]};
              w_c_new  = w_opb[0];
              w_rd     = w_rb;
              w_we     = 1'b1;
              w_c_upd  = 1'b1;
              w_zn_upd = 1'b1;
            end
            2'd2: begin
              w_c_new = 1'b1;
              w_c_upd = 1'b1;
            end
            default: begin
              w_c_new = 1'b0;
              w_c_upd = 1'b1;
            end
          endcase
        end
        4'd7: begin
          case (w_ra)
            2'd2: begin
              w_res = w_opb;
              w_out = 1'b1;
            end
            2'd3: begin
              w_res = I_Port;
              w_rd  = w_rb;
              w_we  = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign w_ccr_we   = w_c_upd | w_zn_upd;
  assign w_ccr_next = {w_zn_upd ? w_res[7] : w_ccr[2],
                       w_zn_upd ? (w_res == 8'h00) : w_ccr[1],
                       w_c_new};

  // Pipeline stage registers and the registered output port
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_ifid_valid  <= 1'b0;
      r_ifid_instr  <= '0;
      r_idex_valid  <= 1'b0;
      r_idex_instr  <= '0;
      r_idex_a      <= '0;
      r_idex_b      <= '0;
      r_exmem_valid <= 1'b0;
      r_exmem_we    <= 1'b0;
      r_exmem_out   <= 1'b0;
      r_exmem_rd    <= '0;
      r_exmem_res   <= '0;
      r_memwb_valid <= 1'b0;
      r_memwb_we    <= 1'b0;
      r_memwb_rd    <= '0;
      r_memwb_res   <= '0;
      r_oport       <= '0;
    end else begin
      r_ifid_valid  <= w_fetch_en;
      r_ifid_instr  <= w_fetch_en ? w_fetch_data : 8'h00;
      r_idex_valid  <= r_ifid_valid;
      r_idex_instr  <= r_ifid_instr;
      r_idex_a      <= w_rd_a;
      r_idex_b      <= w_rd_b;
      r_exmem_valid <= r_idex_valid;
      r_exmem_we    <= w_we;
      r_exmem_out   <= w_out;
      r_exmem_rd    <= w_rd;
      r_exmem_res   <= w_res;
      r_memwb_valid <= r_exmem_valid;
      r_memwb_we    <= r_exmem_we;
      r_memwb_rd    <= r_exmem_rd;
      r_memwb_res   <= r_exmem_res;
      if (r_exmem_valid && r_exmem_out) r_oport <= r_exmem_res;
    end
  end

  assign O_Port = r_oport;
endmodule

// File: tb/tb_cpu_wrapper_v3.sv
// Testbench for cpu_wrapper_v3: directed scenarios plus randomized programs
// checked cycle by cycle against an in-order instruction-set model.
module tb_cpu_wrapper_v3;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] I_Port = 8'h00;
  logic       int_sig = 1'b0;
  logic [7:0] O_Port;

  int errors = 0;
  int checks = 0;

  cpu_wrapper_v3 dut (
    .clk     (clk),
    .rstn    (rstn),
    .I_Port  (I_Port),
    .int_sig (int_sig),
    .O_Port  (O_Port)
  );

  always #5 clk = ~clk;

  logic [7:0] img     [0:255];
  logic [7:0] pre     [0:3];
  logic [7:0] iport_v [0:299];
  logic [7:0] s_r     [0:256][0:3];
  logic [2:0] s_ccr   [0:256];
  logic [7:0] s_out   [0:256];
  int         nexec;

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic load_img();
    for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = img[i];
  endtask

  // One reset edge, then release; presets land before the first fetch edge
  task automatic start_run();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) dut.regfile_inst.regs[i] <= pre[i];
  endtask

  // In-order ISA interpreter; snapshot j = architectural state after j instructions
  task automatic model_run();
    logic [7:0] r [0:3];
    logic       c, z, n;
    logic [7:0] o, ins, t;
    logic [8:0] s;
    int         a, b;
    for (int j = 0; j < 4; j++) r[j] = pre[j];
    c = 1'b0; z = 1'b0; n = 1'b0; o = 8'h00;
    nexec = 0;
    for (int j = 0; j < 4; j++) s_r[0][j] = r[j];
    s_ccr[0] = {n, z, c};
    s_out[0] = o;
    for (int k = 0; k < 256; k++) begin
      ins = img[k];
      a = int'(ins[3:2]);
      b = int'(ins[1:0]);
      if (ins[7:4] == 4'd0) break;
      case (ins[7:4])
        4'd1: r[a] = r[b];
        4'd2: begin s = {1'b0, r[a]} + {1'b0, r[b]}; r[a] = s[7:0]; c = s[8]; z = (r[a] == 0); n = r[a][7]; end
        4'd3: begin c = (r[a] < r[b]); r[a] = r[a] - r[b]; z = (r[a] == 0); n = r[a][7]; end
        4'd4: begin r[a] = r[a] & r[b]; z = (r[a] == 0); n = r[a][7]; end
        4'd5: begin r[a] = r[a] | r[b]; z = (r[a] == 0); n = r[a][7]; end
        4'd6: begin
          if (a == 0)      begin t = {r[b][6:0], c}; c = r[b][7]; r[b] = t; z = (t == 0); n = t[7]; end
          else if (a == 1) begin t = {c, r[b][7:1]}; c = r[b][0]; r[b] = t; z = (t == 0); n = t[7]; end
          else if (a == 2) c = 1'b1;
          else             c = 1'b0;
        end
        4'd7: begin
          if (a == 2)      o = r[b];
          else if (a == 3) r[b] = iport_v[k + 2];
        end
        default: ;
      endcase
      nexec = k + 1;
      for (int j = 0; j < 4; j++) s_r[k + 1][j] = r[j];
      s_ccr[k + 1] = {n, z, c};
      s_out[k + 1] = o;
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > nexec) return nexec;
    return v;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dut.PC.pc_current !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", dut.PC.pc_current); end
    checks++;
    if (dut.ccr_inst.CCR_reg !== 3'b000) begin errors++; $display("FAIL reset_ccr got=%b exp=000", dut.ccr_inst.CCR_reg); end
    checks++;
    if (O_Port !== 8'h00) begin errors++; $display("FAIL reset_oport got=%h exp=00", O_Port); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.regfile_inst.regs[i] !== 8'h00) begin errors++; $display("FAIL reset_reg r%0d got=%h exp=00", i, dut.regfile_inst.regs[i]); end
    end
  endtask

  task automatic load_alu_chain();
    logic [7:0] p [0:9];
    p = '{8'h1D, 8'h2E, 8'h3E, 8'h4E, 8'h5D, 8'h68, 8'h62, 8'h6C, 8'h65, 8'h00};
    clear_img();
    for (int i = 0; i < 10; i++) img[i] = p[i];
    load_img();
    pre = '{8'h00, 8'hF0, 8'h01, 8'h00};
  endtask

  task automatic test_alu_chain();
    load_alu_chain();
    start_run();
    repeat (25) @(negedge clk);
    checks++;
    if (dut.regfile_inst.regs[3] !== 8'hF0) begin errors++; $display("FAIL alu_r3 got=%h exp=F0", dut.regfile_inst.regs[3]); end
    checks++;
    if (dut.regfile_inst.regs[2] !== 8'h03) begin errors++; $display("FAIL alu_r2 got=%h exp=03", dut.regfile_inst.regs[2]); end
    checks++;
    if (dut.regfile_inst.regs[1] !== 8'h78) begin errors++; $display("FAIL alu_r1 got=%h exp=78", dut.regfile_inst.regs[1]); end
    checks++;
    if (dut.ccr_inst.CCR_reg[0] !== 1'b0) begin errors++; $display("FAIL alu_c got=%b exp=0", dut.ccr_inst.CCR_reg[0]); end
  endtask

  task automatic test_forwarding();
    clear_img();
    img[0] = 8'h26; img[1] = 8'h26; img[2] = 8'h26;
    load_img();
    pre = '{8'h00, 8'h05, 8'h03, 8'h00};
    start_run();
    repeat (6) @(negedge clk);   // after edge 5: first two ADDs written back
    checks++;
    if (dut.regfile_inst.regs[1] !== 8'h0B) begin errors++; $display("FAIL fwd_r1_mid got=%h exp=0B", dut.regfile_inst.regs[1]); end
    @(negedge clk);              // after edge 6: third ADD written back
    checks++;
    if (dut.regfile_inst.regs[1] !== 8'h0E) begin errors++; $display("FAIL fwd_r1 got=%h exp=0E", dut.regfile_inst.regs[1]); end
  endtask

  task automatic test_flags();
    clear_img();
    img[0] = 8'h36; img[1] = 8'h25;
    load_img();
    pre = '{8'h00, 8'h01, 8'h02, 8'h00};
    start_run();
    repeat (3) @(negedge clk);   // after edge 2: SUB flags committed
    checks++;
    if (dut.ccr_inst.CCR_reg !== 3'b101) begin errors++; $display("FAIL flags_sub got=%b exp=101", dut.ccr_inst.CCR_reg); end
    @(negedge clk);
    checks++;
    if (dut.ccr_inst.CCR_reg !== 3'b101) begin errors++; $display("FAIL flags_add got=%b exp=101", dut.ccr_inst.CCR_reg); end
    @(negedge clk);
    checks++;
    if (dut.regfile_inst.regs[1] !== 8'hFF) begin errors++; $display("FAIL flags_r1_sub got=%h exp=FF", dut.regfile_inst.regs[1]); end
    @(negedge clk);
    checks++;
    if (dut.regfile_inst.regs[1] !== 8'hFE) begin errors++; $display("FAIL flags_r1_add got=%h exp=FE", dut.regfile_inst.regs[1]); end
  endtask

  task automatic test_io();
    clear_img();
    img[0] = 8'h7F; img[1] = 8'h79;
    load_img();
    pre = '{8'h00, 8'h3C, 8'h00, 8'h00};
    I_Port = 8'hA5;
    start_run();
    repeat (4) @(negedge clk);   // after edge 3: OUT still in MEM
    checks++;
    if (O_Port !== 8'h00) begin errors++; $display("FAIL io_oport_early got=%h exp=00", O_Port); end
    @(negedge clk);              // after edge 4
    checks++;
    if (O_Port !== 8'h3C) begin errors++; $display("FAIL io_oport got=%h exp=3C", O_Port); end
    checks++;
    if (dut.regfile_inst.regs[3] !== 8'hA5) begin errors++; $display("FAIL io_r3 got=%h exp=A5", dut.regfile_inst.regs[3]); end
    I_Port = 8'h00;
  endtask

  task automatic test_halt();
    logic [7:0] pc_a;
    clear_img();
    img[0] = 8'h00; img[1] = 8'h1D;
    load_img();
    pre = '{8'h00, 8'h99, 8'h00, 8'h55};
    start_run();
    int_sig = 1'b1;
    repeat (2) @(negedge clk);
    pc_a = dut.PC.pc_current;
    repeat (10) @(negedge clk);
    int_sig = 1'b0;
    checks++;
    if (dut.PC.pc_current !== pc_a || pc_a > 8'd2) begin
      errors++; $display("FAIL halt_pc got=%h then %h exp=stable<=02", pc_a, dut.PC.pc_current);
    end
    checks++;
    if (dut.regfile_inst.regs[3] !== 8'h55) begin errors++; $display("FAIL halt_r3 got=%h exp=55", dut.regfile_inst.regs[3]); end
  endtask

  task automatic test_midrun_reset();
    load_alu_chain();
    start_run();
    repeat (6) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.PC.pc_current !== 8'h00) begin errors++; $display("FAIL mrst_pc got=%h exp=00", dut.PC.pc_current); end
    checks++;
    if (dut.ccr_inst.CCR_reg !== 3'b000) begin errors++; $display("FAIL mrst_ccr got=%b exp=000", dut.ccr_inst.CCR_reg); end
    checks++;
    if (O_Port !== 8'h00) begin errors++; $display("FAIL mrst_oport got=%h exp=00", O_Port); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.regfile_inst.regs[i] !== 8'h00) begin errors++; $display("FAIL mrst_reg r%0d got=%h exp=00", i, dut.regfile_inst.regs[i]); end
    end
    rstn = 1'b0;
    repeat (4) @(negedge clk);   // no writeback can land before edge 4 of the rerun
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.regfile_inst.regs[i] !== 8'h00) begin errors++; $display("FAIL mrst_noflight r%0d got=%h exp=00", i, dut.regfile_inst.regs[i]); end
    end
    repeat (21) @(negedge clk);
    checks++;
    if (dut.regfile_inst.regs[2] !== 8'h01) begin errors++; $display("FAIL mrst_rerun_r2 got=%h exp=01", dut.regfile_inst.regs[2]); end
    checks++;
    if (dut.regfile_inst.regs[3] !== 8'h00) begin errors++; $display("FAIL mrst_rerun_r3 got=%h exp=00", dut.regfile_inst.regs[3]); end
  endtask

  task automatic test_random();
    int len, ir, ic, io, pcx;
    for (int it = 0; it < 10; it++) begin
      len = int'($urandom_range(20, 4));
      clear_img();
      for (int k = 0; k < len; k++) img[k] = 8'($urandom_range(255, 16));
      for (int j = 0; j < 4; j++) pre[j] = 8'($urandom);
      for (int n = 0; n < 300; n++) iport_v[n] = 8'($urandom);
      load_img();
      model_run();
      start_run();
      I_Port = iport_v[0];
      for (int n = 0; n < len + 12; n++) begin
        @(negedge clk);
        ir  = clampi(n - 3);   // writeback lands 4 edges after fetch
        ic  = clampi(n - 1);   // flags land 2 edges after fetch
        io  = clampi(n - 2);   // O_Port lands 3 edges after fetch
        pcx = (n + 1 < nexec + 1) ? n + 1 : nexec + 1;
        for (int j = 0; j < 4; j++) begin
          checks++;
          if (dut.regfile_inst.regs[j] !== s_r[ir][j]) begin
            errors++; $display("FAIL rnd_reg it=%0d n=%0d r%0d got=%h exp=%h", it, n, j, dut.regfile_inst.regs[j], s_r[ir][j]);
          end
        end
        checks++;
        if (dut.ccr_inst.CCR_reg !== s_ccr[ic]) begin
          errors++; $display("FAIL rnd_ccr it=%0d n=%0d got=%b exp=%b", it, n, dut.ccr_inst.CCR_reg, s_ccr[ic]);
        end
        checks++;
        if (O_Port !== s_out[io]) begin
          errors++; $display("FAIL rnd_oport it=%0d n=%0d got=%h exp=%h", it, n, O_Port, s_out[io]);
        end
        checks++;
        if (dut.PC.pc_current !== 8'(pcx)) begin
          errors++; $display("FAIL rnd_pc it=%0d n=%0d got=%h exp=%h", it, n, dut.PC.pc_current, 8'(pcx));
        end
        I_Port  = iport_v[n + 1];
        int_sig = 1'($urandom);
      end
    end
    int_sig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_forwarding();
    test_flags();
    test_io();
    test_halt();
    test_midrun_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_wrapper_v3.md
# cpu_wrapper_v3

Top-level wrapper of the 8-bit pipelined accumulator-style CPU: program counter, unified 256x8 memory, 4x8 register file, condition-code register and a 5-stage pipeline (IF, ID, EX, MEM, WB) with full forwarding. Executes one 8-bit instruction per cycle. Exchanges data with the outside world only through one 8-bit input port and one registered 8-bit output port. Benches load programs and preset registers by hierarchical access, so the instance names below are part of the interface.

## Interface
- Parameters: none.
- clk  in  1  single system clock; all state updates on its rising edge.
- rstn  in  1  synchronous, active-high reset (port keeps the codebase name `rstn`; sampled on the rising edge of clk).
- I_Port  in  8  external input data, read by IN.
- int_sig  in  1  reserved interrupt request; ignored in this version.
- O_Port  out  8  registered output, written by OUT.
- Required hierarchy:
  - `regfile_inst.regs[0:3]` (8-bit each)
  - `PC.pc_current` (8-bit)
  - `ccr_inst.CCR_reg` (CCR[0]=C, [1]=Z, [2]=N)
  - `mem_inst.mem[0:255]`

## Operation
- Encoding: op = instr[7:4], ra = instr[3:2], rb = instr[1:0].
- op 0: HALT.
  - Once decoded, PC and fetch freeze.
  - Older instructions drain.
  - Only reset exits HALT.
- op 1 MOV: R[ra] <= R[rb]. Flags unchanged.
- op 2 ADD: R[ra] <= R[ra]+R[rb].
  - C = carry-out.
  - Z, N from result.
- op 3 SUB: R[ra] <= R[ra]-R[rb].
  - C = 1 when R[ra] < R[rb] (borrow).
  - Z, N from result.
- op 4 AND / op 5 OR: R[ra] <= R[ra] & / | R[rb].
  - Z, N updated.
  - C unchanged.
- op 6, selected by ra:
  - ra=0, RLC: R[rb] <= {R[rb][6:0], C}; C <= old bit 7.
  - ra=1, RRC: R[rb] <= {C, R[rb][7:1]}; C <= old bit 0.
  - ra=2: SETC, C <= 1.
  - ra=3: CLRC, C <= 0.
  - RLC/RRC update Z and N from the result.
- op 7, selected by ra:
  - ra=2, OUT: O_Port <= R[rb].
  - ra=3, IN: R[rb] <= I_Port, sampled in EX.
  - ra=0/1: NOP.
- op 8–15: NOP. No state change.
- Memory:
  - Asynchronous read, word-addressed by PC.
  - All 256 words initialise to 0x00 at time zero.
  - Not cleared by reset.
- Register file:
  - 4x8 registers, cleared by reset.
  - Write in WB, write-through: a same-cycle read returns the new value.
- Pipeline bubbles:
  - Carry valid=0 and never write registers or CCR, and never halt.
  - Reset-filled 0x00 stages are bubbles, not HALTs.

## Timing
- Reset (rstn=1 at an edge):
  - PC=0, all pipeline stages invalid, regs=0, CCR=0, O_Port=0, halt flag clear.
  - Applies mid-program: in-flight instructions are discarded with no writeback.
- First fetch of mem[0] occurs at the first rising edge with rstn=0.
- PC increments by 1 per cycle and wraps 0xFF -> 0x00.
- Result latency:
  - Register write in WB, 4 edges after the fetch edge.
  - O_Port updates at the end of MEM.
- Forwarding:
  - EX/MEM and MEM/WB results forward to EX operands, younger result first.
  - Back-to-back dependent ALU ops run with no stall.
- Flag timing:
  - CCR updates at the end of EX.
  - The next instruction's EX sees the new C with no stall (SETC then RLC works back-to-back).
- No branches exist, so the pipeline never stalls or flushes.
- Throughput: one instruction per cycle until HALT.

## Test plan
- ALU chain:
  - Setup: after reset, preset R1=F0, R2=01, load 1D 2E 3E 4E 5D 68 62 6C 65 00, run 25 cycles.
  - Expect R3=F0, R2=03, R1=78, C=0.
- Forwarding: R1=05, R2=03; program 26 26 26 00 (ADD R1,R2 x3 into R1 via forwarding) -> R1=0E within 8 cycles after the last fetch.
- Flags:
  - Setup: R1=01, R2=02.
  - SUB 0x36 -> R1=FF, C=1, N=1, Z=0.
  - Then ADD R1,R1 (0x25) -> R1=FE, C=1.
- I/O:
  - I_Port=A5, program 7F 79 00 (IN R3; OUT R1 with R1=3C) -> R3=A5, O_Port=3C.
  - O_Port=00 before the OUT commits.
- HALT: program 00 followed by 1D -> PC stops within 2 cycles of the HALT fetch; R3 unchanged.
- Mid-run reset: assert rstn for one edge during the ALU chain -> PC=0, regs=0, CCR=0, O_Port=0 the next cycle; the program reruns from mem[0].
